// File: rtl/rw_arbiter_pkg.sv
// Shared types and widths for the round-robin read/write arbiter.
package rw_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        BUSY    = 3'd2,
        BACKOFF = 3'd3,
        RESP    = 3'd4
    } rw_arb_state_t;

endpackage

// File: rtl/rw_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or after the pointer, wrapping.
module rr_picker #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic                    o_found,
    output logic [$clog2(NREQ)-1:0] o_idx
);

    localparam int IDX_W = $clog2(NREQ);

    int w_dist;
    int w_best_dist;

    // Distance from the pointer (mod NREQ) ranks each requester; smallest set one wins.
    always_comb begin
        o_found     = 1'b0;
        o_idx       = '0;
        w_dist      = 0;
        w_best_dist = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (i >= int'(i_ptr)) begin
                w_dist = i - int'(i_ptr);
            end else begin
                w_dist = i + NREQ - int'(i_ptr);
            end
            if (i_req[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                o_found     = 1'b1;
                o_idx       = IDX_W'(i);
            end else begin
                w_best_dist = w_best_dist;
            end
        end
    end

endmodule

// File: rtl/rw_arbiter.sv
// Round-robin arbiter sharing one read/write transaction FSM between NREQ requesters.
// Optional feature macro: RW_ARBITER_RETRY_EN enables retry with fixed backoff on failure.
module rw_arbiter #(
    parameter int NREQ      = 2,
    parameter int MAX_RETRY = 3,
    parameter int BACKOFF   = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NREQ-1:0]                         req_valid,
    input  logic [NREQ-1:0]                         req_read,
    input  logic [rw_arbiter_pkg::ADDR_W*NREQ-1:0]  req_addr,
    input  logic [rw_arbiter_pkg::DATA_W*NREQ-1:0]  req_wdata,
    output logic [NREQ-1:0]                         rsp_done,
    output logic                                    rsp_err,
    output logic [rw_arbiter_pkg::DATA_W-1:0]       rsp_rdata,
    output logic [$clog2(NREQ)-1:0]                 grant_id,
    output logic                                    tran_ready,
    output logic                                    read,
    output logic [rw_arbiter_pkg::ADDR_W-1:0]       rw_addr,
    output logic [rw_arbiter_pkg::DATA_W-1:0]       data_down_rw,
    input  logic                                    done,
    input  logic                                    cancel,
    input  logic                                    recv_ready,
    input  logic [rw_arbiter_pkg::DATA_W-1:0]       data_up_rw
);

    import rw_arbiter_pkg::*;

    localparam int IDX_W = $clog2(NREQ);

    rw_arb_state_t     r_state;
    rw_arb_state_t     w_next_state;

    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_grant_id;
    logic [IDX_W-1:0]  w_ptr_next;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_found;
    logic              w_fail;
    logic              w_can_retry;

    logic              r_read;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              r_tran_ready;
    logic [NREQ-1:0]   r_rsp_done;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic              w_tran_ready_nxt;
    logic [NREQ-1:0]   w_rsp_done_nxt;
    logic              w_rsp_err_nxt;
    logic [DATA_W-1:0] w_rsp_rdata_nxt;
    logic [IDX_W-1:0]  w_grant_nxt;

    logic [ADDR_W-1:0] w_addr_arr  [NREQ];
    logic [DATA_W-1:0] w_wdata_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    // A read that completes without recv_ready is as much a failure as a cancel.
    assign w_fail     = done & (cancel | (r_read & ~recv_ready));
    assign w_ptr_next = (r_grant_id == IDX_W'(NREQ - 1)) ? '0 : (r_grant_id + IDX_W'(1));

`ifdef RW_ARBITER_RETRY_EN
    logic [3:0] r_retry_cnt;
    logic [7:0] r_bo_cnt;

    assign w_can_retry = (r_retry_cnt < 4'(MAX_RETRY));

    // Retry count and backoff countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retry_cnt <= 4'd0;
            r_bo_cnt    <= 8'd0;
        end else if ((r_state == IDLE) && w_pick_found) begin
            r_retry_cnt <= 4'd0;
        end else if ((r_state == BUSY) && w_fail && w_can_retry) begin
            r_retry_cnt <= r_retry_cnt + 4'd1;
            r_bo_cnt    <= 8'(BACKOFF);
        end else if ((r_state == rw_arbiter_pkg::BACKOFF) && (r_bo_cnt != 8'd0)) begin
            r_bo_cnt <= r_bo_cnt - 8'd1;
        end else begin
            r_bo_cnt <= r_bo_cnt;
        end
    end
`else
    localparam int unused_cfg = MAX_RETRY + BACKOFF;

    assign w_can_retry = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_next_state = ISSUE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ISSUE: w_next_state = BUSY;
            BUSY: begin
                if (!done) begin
                    w_next_state = BUSY;
                end else if (w_fail && w_can_retry) begin
                    w_next_state = rw_arbiter_pkg::BACKOFF;
                end else begin
                    w_next_state = RESP;
                end
            end
`ifdef RW_ARBITER_RETRY_EN
            rw_arbiter_pkg::BACKOFF: begin
                if (r_bo_cnt == 8'd0) begin
                    w_next_state = ISSUE;
                end else begin
                    w_next_state = rw_arbiter_pkg::BACKOFF;
                end
            end
`endif
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Next-cycle output values, decoded from the upcoming state so every output is a flop.
    always_comb begin
        w_tran_ready_nxt = (w_next_state == ISSUE);
        if (w_next_state == RESP) begin
            w_rsp_done_nxt = {{(NREQ-1){1'b0}}, 1'b1} << r_grant_id;
            w_rsp_err_nxt  = w_fail;
            if (!w_fail && r_read) begin
                w_rsp_rdata_nxt = data_up_rw;
            end else begin
                w_rsp_rdata_nxt = '0;
            end
        end else begin
            w_rsp_done_nxt  = '0;
            w_rsp_err_nxt   = 1'b0;
            w_rsp_rdata_nxt = '0;
        end
        if (w_next_state == IDLE) begin
            w_grant_nxt = '0;
        end else if (r_state == IDLE) begin
            w_grant_nxt = w_pick_idx;
        end else begin
            w_grant_nxt = r_grant_id;
        end
    end

    // Output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tran_ready <= 1'b0;
            r_rsp_done   <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
            r_grant_id   <= '0;
        end else begin
            r_tran_ready <= w_tran_ready_nxt;
            r_rsp_done   <= w_rsp_done_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
            r_rsp_rdata  <= w_rsp_rdata_nxt;
            r_grant_id   <= w_grant_nxt;
        end
    end

    // Payload is captured once at grant so requester-side changes cannot disturb the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_read  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == IDLE) && w_pick_found) begin
            r_read  <= req_read[w_pick_idx];
            r_addr  <= w_addr_arr[w_pick_idx];
            r_wdata <= w_wdata_arr[w_pick_idx];
        end else if (r_state == RESP) begin
            r_ptr <= w_ptr_next;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign rsp_done     = r_rsp_done;
    assign rsp_err      = r_rsp_err;
    assign rsp_rdata    = r_rsp_rdata;
    assign grant_id     = r_grant_id;
    assign tran_ready   = r_tran_ready;
    assign read         = r_read;
    assign rw_addr      = r_addr;
    assign data_down_rw = r_wdata;

endmodule

// File: tb/tb_rw_arbiter.sv
// Directed-vector bench for rw_arbiter (NREQ=2, default parameters).
module tb_rw_arbiter;

`ifdef RW_ARBITER_RETRY_EN
    localparam int N_ATT = 4;
`else
    localparam int N_ATT = 1;
`endif
    localparam int BO_LAT = 9;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_read;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic [1:0]   rsp_done;
    logic         rsp_err;
    logic [63:0]  rsp_rdata;
    logic [0:0]   grant_id;
    logic         tran_ready;
    logic         read;
    logic [15:0]  rw_addr;
    logic [63:0]  data_down_rw;
    logic         done;
    logic         cancel;
    logic         recv_ready;
    logic [63:0]  data_up_rw;

    int n_vec  = 0;
    int n_miss = 0;

    rw_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_read     (req_read),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_done     (rsp_done),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .grant_id     (grant_id),
        .tran_ready   (tran_ready),
        .read         (read),
        .rw_addr      (rw_addr),
        .data_down_rw (data_down_rw),
        .done         (done),
        .cancel       (cancel),
        .recv_ready   (recv_ready),
        .data_up_rw   (data_up_rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic await_start(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (tran_ready === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic finish_txn(input logic c, input logic rr, input logic [63:0] d);
        done       = 1'b1;
        cancel     = c;
        recv_ready = rr;
        data_up_rw = d;
        @(negedge clk);
        done       = 1'b0;
        cancel     = 1'b0;
        recv_ready = 1'b0;
        data_up_rw = 64'd0;
    endtask

    task automatic run_exhaust(input string tag, input logic c, input logic rr, input logic [1:0] exp_done);
        int lat;
        for (int a = 0; a < N_ATT; a++) begin
            await_start(lat);
            chk_eq({tag, "_lat"}, 64'(lat), (a == 0) ? 64'd1 : 64'(BO_LAT));
            repeat (2) @(negedge clk);
            finish_txn(c, rr, 64'hFFFF_0000_FFFF_0000);
            if (a < N_ATT - 1) chk_eq({tag, "_nodone"}, 64'(rsp_done), 64'd0);
        end
        chk_eq({tag, "_done"}, 64'(rsp_done), 64'(exp_done));
        chk_eq({tag, "_err"}, 64'(rsp_err), 64'd1);
        chk_eq({tag, "_rdata"}, rsp_rdata, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [1:0] exp_oh;
        rst = 1'b1; req_valid = 2'b00; req_read = 2'b00; req_addr = 32'd0; req_wdata = 128'd0;
        done = 1'b0; cancel = 1'b0; recv_ready = 1'b0; data_up_rw = 64'd0;
        repeat (3) @(negedge clk);
        chk_eq("rst_tran_ready", 64'(tran_ready), 64'd0);
        chk_eq("rst_rsp_done", 64'(rsp_done), 64'd0);
        chk_eq("rst_grant", 64'(grant_id), 64'd0);
        chk_eq("rst_addr", 64'(rw_addr), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single write from requester 0
        req_valid = 2'b01; req_read = 2'b00;
        req_addr[15:0] = 16'h1234; req_wdata[63:0] = 64'hDEADBEEF_00000001;
        await_start(lat);
        chk_eq("w_lat", 64'(lat), 64'd1);
        chk_eq("w_addr", 64'(rw_addr), 64'h1234);
        chk_eq("w_data", data_down_rw, 64'hDEADBEEF_00000001);
        chk_eq("w_read", 64'(read), 64'd0);
        chk_eq("w_grant", 64'(grant_id), 64'd0);
        req_addr[15:0] = 16'hFFFF; req_wdata[63:0] = 64'd0;
        @(negedge clk);
        chk_eq("w_pulse", 64'(tran_ready), 64'd0);
        repeat (4) @(negedge clk);
        chk_eq("w_addr_hold", 64'(rw_addr), 64'h1234);
        chk_eq("w_data_hold", data_down_rw, 64'hDEADBEEF_00000001);
        finish_txn(1'b0, 1'b0, 64'd0);
        chk_eq("w_done", 64'(rsp_done), 64'h1);
        chk_eq("w_err", 64'(rsp_err), 64'd0);
        req_valid = 2'b00;
        @(negedge clk);
        chk_eq("w_done_1cyc", 64'(rsp_done), 64'd0);
        chk_eq("w_idle_grant", 64'(grant_id), 64'd0);

        // Read from requester 1; a done during ISSUE must be ignored
        req_valid = 2'b10; req_read = 2'b10; req_addr[31:16] = 16'h00A0;
        await_start(lat);
        chk_eq("r_lat", 64'(lat), 64'd1);
        chk_eq("r_grant", 64'(grant_id), 64'd1);
        chk_eq("r_read", 64'(read), 64'd1);
        chk_eq("r_addr", 64'(rw_addr), 64'h00A0);
        done = 1'b1; cancel = 1'b1;
        @(negedge clk);
        done = 1'b0; cancel = 1'b0;
        chk_eq("r_issue_done_ign", 64'(rsp_done), 64'd0);
        @(negedge clk);
        finish_txn(1'b0, 1'b1, 64'hA5A5_A5A5_0000_FFFF);
        chk_eq("r_done", 64'(rsp_done), 64'h2);
        chk_eq("r_rdata", rsp_rdata, 64'hA5A5_A5A5_0000_FFFF);
        chk_eq("r_err", 64'(rsp_err), 64'd0);
        req_valid = 2'b00; req_read = 2'b00;
        @(negedge clk);

        // Fairness: both valid for four transactions
        req_addr = {16'h2000, 16'h1000};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            await_start(lat);
            chk_eq("rr_lat", 64'(lat), (k == 0) ? 64'd1 : 64'd2);
            chk_eq("rr_grant", 64'(grant_id), 64'(k % 2));
            chk_eq("rr_addr", 64'(rw_addr), (k % 2 == 0) ? 64'h1000 : 64'h2000);
            @(negedge clk);
            finish_txn(1'b0, 1'b0, 64'd0);
            exp_oh = 2'b01 << (k % 2);
            chk_eq("rr_done", 64'(rsp_done), 64'(exp_oh));
        end
        req_valid = 2'b00;
        @(negedge clk);

        // Lone requester re-requesting is granted again
        req_addr[31:16] = 16'h3000; req_valid = 2'b10;
        for (int k = 0; k < 2; k++) begin
            await_start(lat);
            chk_eq("re_lat", 64'(lat), (k == 0) ? 64'd1 : 64'd2);
            chk_eq("re_grant", 64'(grant_id), 64'd1);
            @(negedge clk);
            finish_txn(1'b0, 1'b0, 64'd0);
            chk_eq("re_done", 64'(rsp_done), 64'h2);
        end
        req_valid = 2'b00;
        @(negedge clk);

        // Failure paths: always-cancel write, read without recv_ready
        req_valid = 2'b01; req_read = 2'b00;
        run_exhaust("ex_cancel", 1'b1, 1'b0, 2'b01);
        req_valid = 2'b00;
        @(negedge clk);
        req_valid = 2'b10; req_read = 2'b10;
        run_exhaust("ex_norecv", 1'b0, 1'b0, 2'b10);
        req_valid = 2'b00; req_read = 2'b00;
        @(negedge clk);

`ifdef RW_ARBITER_RETRY_EN
        // Two cancels then success
        req_valid = 2'b01;
        await_start(lat);
        chk_eq("rt_lat0", 64'(lat), 64'd1);
        @(negedge clk);
        finish_txn(1'b1, 1'b0, 64'd0);
        await_start(lat);
        chk_eq("rt_lat1", 64'(lat), 64'(BO_LAT));
        @(negedge clk);
        finish_txn(1'b1, 1'b0, 64'd0);
        await_start(lat);
        chk_eq("rt_lat2", 64'(lat), 64'(BO_LAT));
        @(negedge clk);
        finish_txn(1'b0, 1'b0, 64'd0);
        chk_eq("rt_done", 64'(rsp_done), 64'h1);
        chk_eq("rt_err", 64'(rsp_err), 64'd0);
        req_valid = 2'b00;
        @(negedge clk);
`endif

        // Reset while BUSY: no completion, outputs cleared, fresh grant afterwards
        req_valid = 2'b01; req_addr[15:0] = 16'h5555;
        await_start(lat);
        chk_eq("rb_lat", 64'(lat), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1; req_valid = 2'b00;
        @(negedge clk);
        chk_eq("rb_tran_ready", 64'(tran_ready), 64'd0);
        chk_eq("rb_grant", 64'(grant_id), 64'd0);
        chk_eq("rb_addr", 64'(rw_addr), 64'd0);
        chk_eq("rb_rsp_done", 64'(rsp_done), 64'd0);
        rst = 1'b0; done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk_eq("rb_stale_done", 64'(rsp_done), 64'd0);
        req_valid = 2'b10; req_addr[31:16] = 16'h7777;
        await_start(lat);
        chk_eq("rb_new_lat", 64'(lat), 64'd1);
        chk_eq("rb_new_grant", 64'(grant_id), 64'd1);
        chk_eq("rb_new_addr", 64'(rw_addr), 64'h7777);
        @(negedge clk);
        finish_txn(1'b0, 1'b0, 64'd0);
        chk_eq("rb_new_done", 64'(rsp_done), 64'h2);
        req_valid = 2'b00;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
